dense_layer1_8_mac: RTL and testbench

Sequential multiply-accumulate engine for one fully connected layer, downstream of the layer's weight and bias loaders. It consumes the flat weight and bias vectors those loaders hold, plus the layer input vector. For each neuron it computes the dot product with a single time-shared MAC, adds the bias, rescales, saturates and optionally applies ReLU. It presents all neuron outputs as one flat vector to the next layer.

---
 rtl/dense_layer1_8_mac.sv | 148 ++++++++++++++
 tb/tb_dense_layer1_8_mac.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/dense_layer1_8_mac.sv
// Time-shared MAC engine for one fully connected layer: dot product, bias, rescale, saturate.
// Optional ReLU on the written result is enabled by defining DENSE_RELU_EN.
module dense_layer1_8_mac #(
  parameter int IN_SIZE  = 1,
  parameter int OUT_SIZE = 8,
  parameter int W        = 8,
  parameter int FRAC     = 4,
  parameter int ACC_W    = 20
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic [IN_SIZE*W-1:0]           x_in,
  input  logic [IN_SIZE*OUT_SIZE*W-1:0]  weights_in,
  input  logic [OUT_SIZE*W-1:0]          bias_in,
  output logic [OUT_SIZE*W-1:0]          y_out,
  output logic                           busy,
  output logic                           done
);

  // state | meaning
  // IDLE  | waiting for start; y_out holds last result (or 0 after reset)
  // MAC   | accumulate x[i]*w[j][i], one input per cycle
  // BIAS  | add bias, rescale, saturate, write y_out[j]
  // DONE  | results stable until start drops

  localparam int IW = (IN_SIZE > 1) ? $clog2(IN_SIZE) : 1;
  localparam int JW = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(IN_SIZE - 1);
  localparam logic [JW-1:0] J_LAST = JW'(OUT_SIZE - 1);
  localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'((2 ** (W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_LO = -ACC_W'(2 ** (W - 1));

  typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_DONE} state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             i_q, i_d;
  logic [JW-1:0]             j_q, j_d;
  logic signed [ACC_W-1:0]   acc_q, acc_d;
  logic [W-1:0]              y_q [OUT_SIZE];
  logic [W-1:0]              y_d [OUT_SIZE];

  logic signed [W-1:0]       x_arr [IN_SIZE];
  logic signed [W-1:0]       w_arr [OUT_SIZE][IN_SIZE];
  logic signed [W-1:0]       b_arr [OUT_SIZE];
  logic signed [W-1:0]       x_sel, w_sel, b_sel;
  logic signed [2*W-1:0]     prod;
  logic signed [ACC_W-1:0]   prod_ext, bias_ext, sum, r;
  logic [W-1:0]              res;

  always_comb begin
    for (int i = 0; i < IN_SIZE; i++) begin
      x_arr[i] = x_in[i*W +: W];
    end
    for (int j = 0; j < OUT_SIZE; j++) begin
      b_arr[j] = bias_in[j*W +: W];
      y_out[j*W +: W] = y_q[j];
      for (int i = 0; i < IN_SIZE; i++) begin
        w_arr[j][i] = weights_in[(j*IN_SIZE+i)*W +: W];
      end
    end
  end

  always_comb begin
    x_sel    = x_arr[i_q];
    w_sel    = w_arr[j_q][i_q];
    b_sel    = b_arr[j_q];
    prod     = x_sel * w_sel;
    prod_ext = {{(ACC_W-2*W){prod[2*W-1]}}, prod};
    bias_ext = {{(ACC_W-W){b_sel[W-1]}}, b_sel} <<< FRAC;
    sum      = acc_q + bias_ext;
    r        = sum >>> FRAC;
    if (r > SAT_HI) begin
      res = SAT_HI[W-1:0];
    end else if (r < SAT_LO) begin
      res = SAT_LO[W-1:0];
    end else begin
      res = r[W-1:0];
    end
`ifdef DENSE_RELU_EN
    if (res[W-1]) begin
      res = '0;
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    j_d     = j_q;
    acc_d   = acc_q;
    y_d     = y_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          for (int j = 0; j < OUT_SIZE; j++) y_d[j] = '0;
          i_d     = '0;
          j_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_MAC: begin
        acc_d = acc_q + prod_ext;
        if (i_q == I_LAST) begin
          state_d = S_BIAS;
        end else begin
          i_d = i_q + 1'b1;
        end
      end
      S_BIAS: begin
        y_d[j_q] = res;
        if (j_q == J_LAST) begin
          state_d = S_DONE;
        end else begin
          j_d     = j_q + 1'b1;
          i_d     = '0;
          acc_d   = '0;
          state_d = S_MAC;
        end
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      for (int j = 0; j < OUT_SIZE; j++) y_q[j] <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      acc_q   <= acc_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q == S_MAC) || (state_q == S_BIAS);
  assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_dense_layer1_8_mac.sv
// Scoreboarded random/directed bench for dense_layer1_8_mac against an arithmetic reference model.
module tb_dense_layer1_8_mac;
  localparam int IN_SIZE  = 1;
  localparam int OUT_SIZE = 8;
  localparam int W        = 8;
  localparam int FRAC     = 4;
  localparam int ACC_W    = 20;
  localparam int XW = IN_SIZE * W;
  localparam int WW = IN_SIZE * OUT_SIZE * W;
  localparam int BW = OUT_SIZE * W;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [XW-1:0] x_in = '0;
  logic [WW-1:0] weights_in = '0;
  logic [BW-1:0] bias_in = '0;
  logic [BW-1:0] y_out;
  logic          busy, done;

  int errors = 0;
  int checks = 0;
  logic [BW-1:0] exp_q [$];
  logic done_prev = 1'b0;

  always #5 clk = ~clk;

  dense_layer1_8_mac #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .W(W), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_in(x_in), .weights_in(weights_in),
    .bias_in(bias_in), .y_out(y_out), .busy(busy), .done(done)
  );

  task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: real-valued dot product in integer units of 2^-2FRAC, floor rescale, clamp.
  function automatic logic [BW-1:0] model(input logic [XW-1:0] x, input logic [WW-1:0] w,
                                          input logic [BW-1:0] b);
    logic [BW-1:0] out;
    logic signed [W-1:0] xe, we, be;
    longint acc, r;
    out = '0;
    for (int j = 0; j < OUT_SIZE; j++) begin
      acc = 0;
      for (int i = 0; i < IN_SIZE; i++) begin
        xe = x[i*W +: W];
        we = w[(j*IN_SIZE+i)*W +: W];
        acc += longint'(xe) * longint'(we);
      end
      be = b[j*W +: W];
      acc += longint'(be) * (longint'(1) << FRAC);
      r = acc >>> FRAC;
      if (r > (2 ** (W - 1)) - 1) r = (2 ** (W - 1)) - 1;
      if (r < -(2 ** (W - 1))) r = -(2 ** (W - 1));
`ifdef DENSE_RELU_EN
      if (r < 0) r = 0;
`endif
      out[j*W +: W] = r[W-1:0];
    end
    return out;
  endfunction

  // Monitor: compare y_out with the oldest expectation whenever done rises.
  always @(negedge clk) begin
    if (rst_n && done && !done_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: actual=done with empty scoreboard required=no done");
      end else begin
        check("y_out", y_out, exp_q.pop_front());
      end
    end
    if (busy && done) begin
      checks++;
      errors++;
      $display("FAIL busy_done_overlap: actual=both high required=exclusive");
    end
    done_prev = done;
  end

  task automatic run(input logic [XW-1:0] x, input logic [WW-1:0] w, input logic [BW-1:0] b);
    int cnt, guard;
    x_in = x;
    weights_in = w;
    bias_in = b;
    exp_q.push_back(model(x, w, b));
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("busy_after_start", BW'(busy), BW'(1));
    check("y_cleared_on_start", y_out, '0);
    cnt = 0;
    guard = 0;
    while (!done && guard < 100) begin
      if (busy) cnt++;
      @(negedge clk);
      guard++;
    end
    check("done_reached", BW'(done), BW'(1));
    check("busy_cycles", BW'(cnt), BW'(OUT_SIZE * (IN_SIZE + 1)));
    repeat (3) @(negedge clk);
    check("done_hold", BW'({done, busy}), BW'(2'b10));
    start = 1'b0;
    @(negedge clk);
    check("back_to_idle", BW'({done, busy}), BW'(2'b00));
  endtask

  function automatic logic [WW-1:0] rep_w(input logic [W-1:0] v);
    logic [WW-1:0] t;
    for (int k = 0; k < IN_SIZE * OUT_SIZE; k++) t[k*W +: W] = v;
    return t;
  endfunction

  function automatic logic [BW-1:0] rep_b(input logic [W-1:0] v);
    logic [BW-1:0] t;
    for (int k = 0; k < OUT_SIZE; k++) t[k*W +: W] = v;
    return t;
  endfunction

  initial begin
    logic [WW-1:0] wv;
    logic [BW-1:0] exp_pat;
    int guard;
    repeat (2) @(negedge clk);
    check("reset_y", y_out, '0);
    check("reset_flags", BW'({done, busy}), BW'(2'b00));
    rst_n = 1'b1;
    @(negedge clk);

    run(8'h10, rep_w(8'h20), rep_b(8'h08));
    exp_pat = rep_b(8'h28);
    check("default_const", model(8'h10, rep_w(8'h20), rep_b(8'h08)), exp_pat);
    check("default_y", y_out, exp_pat);
    run(8'h7F, rep_w(8'h7F), rep_b(8'h7F));
    run(8'h7F, rep_w(8'h80), rep_b(8'h80));
    run(8'h01, rep_w(8'hFF), rep_b(8'h00));
    run(8'h10, rep_w(8'hE0), rep_b(8'h00));
    for (int j = 0; j < OUT_SIZE; j++)
      wv[j*W +: W] = (j < 7) ? W'(8'h10 * (j + 1)) : 8'h7F;
    run(8'h10, wv, '0);
    exp_pat = 64'h7F70_6050_4030_2010;
    check("per_neuron_order", y_out, exp_pat);
    for (int n = 0; n < 8; n++)
      run(XW'($urandom), {$urandom, $urandom}, {$urandom, $urandom});

    // Mid-run reset discards partial results.
    x_in = 8'h10;
    weights_in = rep_w(8'h20);
    bias_in = rep_b(8'h08);
    start = 1'b1;
    @(posedge clk);
    guard = 0;
    while (!busy && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    repeat (5) @(negedge clk);
    check("partial_y0", BW'(y_out[7:0]), BW'(8'h28));
    rst_n = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check("midrun_reset_y", y_out, '0);
    check("midrun_reset_flags", BW'({done, busy}), BW'(2'b00));
    rst_n = 1'b1;
    @(negedge clk);
    run(8'h10, rep_w(8'h20), rep_b(8'h08));
    run(XW'($urandom), {$urandom, $urandom}, {$urandom, $urandom});

    repeat (3) @(negedge clk);
    check("scoreboard_drained", BW'(exp_q.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
